// File: rtl/render_pkg.sv
// Shared render types: framebuffer writer states, fragment record, far-plane depth.
package render_pkg;

    typedef enum logic [1:0] {UNINIT, RUN, DRAIN, CLEAR} fb_state_t;

    // Field widths of the default 320x320, 12-bit depth, 4-bit color geometry
    localparam int FRAG_ADDR_W  = 17;
    localparam int FRAG_DEPTH_W = 12;
    localparam int FRAG_COLOR_W = 4;

    typedef struct packed {
        logic [FRAG_ADDR_W-1:0]  addr;
        logic [FRAG_DEPTH_W-1:0] depth;
        logic [FRAG_COLOR_W-1:0] color;
    } fragment_t;

    localparam logic [31:0] DEPTH_FAR = '1;

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? '1 : s[31:0];
    endfunction

endpackage

// File: rtl/depth_buffer_ram.sv
// Depth buffer storage: one read port, one write port, 1-cycle read latency, read-first.
module depth_buffer_ram #(
    parameter int DATAWIDTH = 12,
    parameter int ADDRWIDTH = 17
) (
    input  logic                 clk,
    input  logic                 re,
    input  logic [ADDRWIDTH-1:0] raddr,
    output logic [DATAWIDTH-1:0] rdata,
    input  logic                 we,
    input  logic [ADDRWIDTH-1:0] waddr,
    input  logic [DATAWIDTH-1:0] wdata
);

    logic [DATAWIDTH-1:0] mem [2**ADDRWIDTH];

    // Same-address read and write in one cycle returns the old word
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/depth_framebuffer_writer.sv
// Depth-tested fragment sink with full-screen clear sequencer.
// Define DEPTH_FB_STATS_EN to add saturating pass/reject counters.
module depth_framebuffer_writer
    import render_pkg::*;
#(
    parameter int DATAWIDTH     = 12,
    parameter int COLORWIDTH    = 4,
    parameter int SCREEN_WIDTH  = 320,
    parameter int SCREEN_HEIGHT = 320,
    parameter int ADDRWIDTH     = $clog2(SCREEN_WIDTH*SCREEN_HEIGHT),
    parameter logic [COLORWIDTH-1:0] CLEAR_COLOR = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDRWIDTH-1:0]  i_fb_addr_write,
    input  logic                  i_fb_write_en,
    input  logic [DATAWIDTH-1:0]  i_fb_depth_data,
    input  logic [COLORWIDTH-1:0] i_fb_color_data,
    input  logic                  i_clear,
    output logic                  o_ready,
    output logic                  o_clear_done,
    output logic [ADDRWIDTH-1:0]  o_color_addr,
    output logic [COLORWIDTH-1:0] o_color_data,
    output logic                  o_color_we
`ifdef DEPTH_FB_STATS_EN
    ,
    output logic [31:0]           o_pass_count,
    output logic [31:0]           o_reject_count
`endif
);

    localparam logic [31:0]          NUM_PIX   = 32'(SCREEN_WIDTH*SCREEN_HEIGHT);
    localparam logic [ADDRWIDTH-1:0] LAST_ADDR = ADDRWIDTH'(SCREEN_WIDTH*SCREEN_HEIGHT-1);
    localparam logic [DATAWIDTH-1:0] FAR       = DEPTH_FAR[DATAWIDTH-1:0];

    typedef struct packed {
        logic [ADDRWIDTH-1:0]  addr;
        logic [DATAWIDTH-1:0]  depth;
        logic [COLORWIDTH-1:0] color;
    } s1_frag_t;

    fb_state_t            state, state_nxt;
    logic [ADDRWIDTH-1:0] clr_cnt;
    logic [2:1]           vld_pipe;
    s1_frag_t             s1;
    logic                 s1_fwd;
    logic [DATAWIDTH-1:0] s1_fwd_depth;
    logic                 ready, clr_active, clr_last;
    logic                 in_range, accept, pass, fwd_hit;
    logic [DATAWIDTH-1:0] ram_rdata, stored;
    logic                 ram_we;
    logic [ADDRWIDTH-1:0] ram_waddr;
    logic [DATAWIDTH-1:0] ram_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= UNINIT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            UNINIT:  if (i_clear) state_nxt = CLEAR;
            RUN:     if (i_clear) state_nxt = DRAIN;
            DRAIN:   if (vld_pipe == '0) state_nxt = CLEAR;
            CLEAR:   if (clr_last) state_nxt = RUN;
            default: state_nxt = UNINIT;
        endcase
    end

    always_comb begin
        ready      = (state == RUN);
        clr_active = (state == CLEAR);
    end

    assign o_ready  = ready;
    assign clr_last = clr_active && (clr_cnt == LAST_ADDR);
    assign in_range = 32'(i_fb_addr_write) < NUM_PIX;
    assign accept   = ready && i_fb_write_en && in_range;

    // Read-first RAM misses a write landing on the same edge as the read; s1_fwd covers it
    assign stored  = s1_fwd ? s1_fwd_depth : ram_rdata;
    assign pass    = vld_pipe[1] && (s1.depth < stored);
    assign fwd_hit = pass && accept && (i_fb_addr_write == s1.addr);

    assign ram_we    = clr_active || pass;
    assign ram_waddr = clr_active ? clr_cnt : s1.addr;
    assign ram_wdata = clr_active ? FAR : s1.depth;

    depth_buffer_ram #(
        .DATAWIDTH(DATAWIDTH),
        .ADDRWIDTH(ADDRWIDTH)
    ) u_depth_ram (
        .clk   (clk),
        .re    (accept),
        .raddr (i_fb_addr_write),
        .rdata (ram_rdata),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe     <= '0;
            s1           <= '0;
            s1_fwd       <= 1'b0;
            s1_fwd_depth <= '0;
            clr_cnt      <= '0;
            o_color_we   <= 1'b0;
            o_color_addr <= '0;
            o_color_data <= '0;
            o_clear_done <= 1'b0;
        end else begin
            vld_pipe     <= {pass, accept};
            if (accept) s1 <= '{addr: i_fb_addr_write, depth: i_fb_depth_data, color: i_fb_color_data};
            s1_fwd       <= fwd_hit;
            s1_fwd_depth <= s1.depth;
            clr_cnt      <= clr_active ? clr_cnt + 1'b1 : '0;
            // Pipeline is empty while clearing, so the two write sources never collide
            o_color_we   <= clr_active || pass;
            o_color_addr <= clr_active ? clr_cnt : s1.addr;
            o_color_data <= clr_active ? CLEAR_COLOR : s1.color;
            o_clear_done <= clr_last;
        end
    end

`ifdef DEPTH_FB_STATS_EN
    logic dropped, failed, clr_entry;

    assign dropped   = i_fb_write_en && !accept;
    assign failed    = vld_pipe[1] && !pass;
    assign clr_entry = (state_nxt == CLEAR) && (state != CLEAR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_pass_count   <= '0;
            o_reject_count <= '0;
        end else if (clr_entry) begin
            o_pass_count   <= '0;
            o_reject_count <= '0;
        end else begin
            o_pass_count   <= sat_add32(o_pass_count, 32'(pass));
            o_reject_count <= sat_add32(o_reject_count, 32'(dropped) + 32'(failed));
        end
    end
`endif

endmodule

// File: tb/tb_depth_framebuffer_writer.sv
// Scoreboard bench for depth_framebuffer_writer on a 4x4 screen.
module tb_depth_framebuffer_writer;
    import render_pkg::*;

    localparam int DW = 12, CW = 4, W = 4, H = 4, AW = 5, NPIX = W*H;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] i_fb_addr_write;
    logic          i_fb_write_en;
    logic [DW-1:0] i_fb_depth_data;
    logic [CW-1:0] i_fb_color_data;
    logic          i_clear;
    logic          o_ready, o_clear_done, o_color_we;
    logic [AW-1:0] o_color_addr;
    logic [CW-1:0] o_color_data;
`ifdef DEPTH_FB_STATS_EN
    logic [31:0]   o_pass_count, o_reject_count;
`endif

    always #5 clk = ~clk;

    depth_framebuffer_writer #(
        .DATAWIDTH(DW), .COLORWIDTH(CW), .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H),
        .ADDRWIDTH(AW), .CLEAR_COLOR('0)
    ) dut (
        .clk(clk), .rst(rst),
        .i_fb_addr_write(i_fb_addr_write), .i_fb_write_en(i_fb_write_en),
        .i_fb_depth_data(i_fb_depth_data), .i_fb_color_data(i_fb_color_data),
        .i_clear(i_clear), .o_ready(o_ready), .o_clear_done(o_clear_done),
        .o_color_addr(o_color_addr), .o_color_data(o_color_data), .o_color_we(o_color_we)
`ifdef DEPTH_FB_STATS_EN
        , .o_pass_count(o_pass_count), .o_reject_count(o_reject_count)
`endif
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [CW-1:0] data;
    } cw_t;

    cw_t exp_q[$];
    int  checks = 0, errors = 0, done_pulses = 0;
    bit  mon_en = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic cw_t mk(input int a, input int d);
        return '{addr: AW'(a), data: CW'(d)};
    endfunction

    // Monitor: every color write must match the head of the expected queue
    initial forever begin
        @(negedge clk);
        if (o_clear_done) done_pulses++;
        if (mon_en && o_color_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %0d expected none", o_color_addr, o_color_data);
            end else begin
                cw_t e;
                e = exp_q.pop_front();
                check("color_addr", 32'(o_color_addr), 32'(e.addr));
                check("color_data", 32'(o_color_data), 32'(e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frag(input int a, input int d, input int c);
        i_fb_write_en   = 1'b1;
        i_fb_addr_write = AW'(a);
        i_fb_depth_data = DW'(d);
        i_fb_color_data = CW'(c);
        tick();
        i_fb_write_en   = 1'b0;
    endtask

    task automatic push_clear();
        for (int i = 0; i < NPIX; i++) exp_q.push_back(mk(i, 0));
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!o_ready && n < 100) begin
            tick();
            n++;
        end
    endtask

    fragment_t seq[3];

    initial begin
        int n, d0;
        rst = 1'b1; i_clear = 1'b0; i_fb_write_en = 1'b0;
        i_fb_addr_write = '0; i_fb_depth_data = '0; i_fb_color_data = '0;
        seq[0] = '{addr: 17'd9, depth: 12'd300, color: 4'd1};
        seq[1] = '{addr: 17'd9, depth: 12'd200, color: 4'd2};
        seq[2] = '{addr: 17'd9, depth: 12'd250, color: 4'd3};
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(o_ready), 0);
        check("rst_we", 32'(o_color_we), 0);
        check("rst_done", 32'(o_clear_done), 0);
        check("rst_addr", 32'(o_color_addr), 0);
        check("rst_data", 32'(o_color_data), 0);
        rst = 1'b0;
        frag(3, 1, 1);
        tick();
        check("uninit_ready", 32'(o_ready), 0);

        // Initial clear from UNINIT
        push_clear();
        d0 = done_pulses;
        i_clear = 1'b1; tick(); i_clear = 1'b0;
        wait_ready(n);
        check("clear_cycles", 32'(n), 16);
        tick();
        check("clear_done_pulses", 32'(done_pulses - d0), 1);

        // Single write and 2-cycle latency, then a farther repeat
        exp_q.push_back(mk(5, 3));
        frag(5, 100, 3);
        check("latency_s1_we", 32'(o_color_we), 0);
        tick();
        check("latency_s2_we", 32'(o_color_we), 1);
        tick();
        frag(5, 200, 7);
        repeat (3) tick();

        // Back-to-back same address exercises forwarding
        exp_q.push_back(mk(9, 1));
        exp_q.push_back(mk(9, 2));
        for (int i = 0; i < 3; i++) frag(int'(seq[i].addr), int'(seq[i].depth), int'(seq[i].color));
        repeat (3) tick();

        // Equal depth loses, spaced and consecutive
        exp_q.push_back(mk(2, 4));
        frag(2, 50, 4); tick(); frag(2, 50, 6);
        exp_q.push_back(mk(3, 1));
        frag(3, 60, 1); frag(3, 60, 2);
        repeat (3) tick();

        // Out of range is dropped and must not alias onto address 0
        frag(16, 10, 5);
        repeat (3) tick();
        exp_q.push_back(mk(0, 8));
        frag(0, 4000, 8);
        repeat (3) tick();
`ifdef DEPTH_FB_STATS_EN
        check("pass_count", o_pass_count, 6);
        check("reject_count", o_reject_count, 5);
`endif

        // Clear from RUN: fragment in DRAIN, fragments and a stray i_clear during CLEAR
        push_clear();
        d0 = done_pulses;
        i_clear = 1'b1; tick(); i_clear = 1'b0;
        frag(6, 1, 1);
        frag(7, 1, 1);
        i_clear = 1'b1; frag(8, 1, 1); i_clear = 1'b0;
        wait_ready(n);
        check("clear2_ready", 32'(o_ready), 1);
        tick();
        check("clear2_done_pulses", 32'(done_pulses - d0), 1);
`ifdef DEPTH_FB_STATS_EN
        check("clear2_pass_count", o_pass_count, 0);
        check("clear2_reject_count", o_reject_count, 2);
`endif
        exp_q.push_back(mk(5, 9));
        frag(5, 4000, 9);
        exp_q.push_back(mk(9, 2));
        frag(9, 4094, 2);
        repeat (4) tick();

        // Reset in the middle of a clear
        mon_en = 1'b0;
        i_clear = 1'b1; tick(); i_clear = 1'b0;
        repeat (6) tick();
        rst = 1'b1;
        #1;
        check("abort_we", 32'(o_color_we), 0);
        check("abort_ready", 32'(o_ready), 0);
        check("abort_addr", 32'(o_color_addr), 0);
        check("abort_data", 32'(o_color_data), 0);
`ifdef DEPTH_FB_STATS_EN
        check("abort_reject_count", o_reject_count, 0);
`endif
        tick();
        rst = 1'b0;
        mon_en = 1'b1;
        frag(1, 5, 5);
        repeat (4) tick();
        check("abort_uninit_ready", 32'(o_ready), 0);
        push_clear();
        i_clear = 1'b1; tick(); i_clear = 1'b0;
        wait_ready(n);
        check("clear3_cycles", 32'(n), 16);
        exp_q.push_back(mk(1, 5));
        frag(1, 5, 5);
        repeat (4) tick();

        check("queue_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
